// File: rtl/l1_icache_refill_ctrl.sv
// l1_icache_refill_ctrl: two-port L1 I-cache miss arbiter, refill streamer and victim-way selector
module l1_icache_refill_ctrl #(
  parameter int LINE_BYTES  = 64,
  parameter int ASSOC       = 8,
  parameter int SETS        = 128,
  parameter int OFFSET_BITS = 6,
  localparam int BEATS      = LINE_BYTES / 8,
  localparam int BEAT_BITS  = $clog2(BEATS),
  localparam int WAY_BITS   = $clog2(ASSOC),
  localparam int INDEX_BITS = $clog2(SETS),
  localparam int TAG_BITS   = 64 - INDEX_BITS - OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid_if1,
  input  logic [63:0]           miss_addr_if1,
  output logic                  miss_ready_if1,
  output logic                  fill_done_if1,
  input  logic                  miss_valid_if2,
  input  logic [63:0]           miss_addr_if2,
  output logic                  miss_ready_if2,
  output logic                  fill_done_if2,
  output logic                  mem_req_valid,
  output logic [63:0]           mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [63:0]           mem_resp_data,
  output logic                  fill_we,
  output logic [INDEX_BITS-1:0] fill_set,
  output logic [WAY_BITS-1:0]   fill_way,
  output logic [BEAT_BITS-1:0]  fill_beat,
  output logic [63:0]           fill_data,
  output logic                  fill_tag_we,
  output logic [TAG_BITS-1:0]   fill_tag,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  state_e                state_q, state_d;
  logic                  rr_q, rr_d;
  logic [63:0]           line_q, line_d;
  logic [1:0]            own_q, own_d;
  logic [WAY_BITS-1:0]   way_q, way_d;
  logic [BEAT_BITS-1:0]  beat_q, beat_d;
  logic [WAY_BITS-1:0]   victim_q [SETS];
  logic [63:0]           line1, line2, gline;
  logic                  same, g1, g2, m1, m2;
  assign line1 = miss_addr_if1 & ~64'(LINE_BYTES - 1);
  assign line2 = miss_addr_if2 & ~64'(LINE_BYTES - 1);
  assign same  = line1 == line2;
  assign g1    = miss_valid_if1 && (!miss_valid_if2 || same || !rr_q);
  assign g2    = miss_valid_if2 && (!miss_valid_if1 || same || rr_q);
  assign gline = g1 ? line1 : line2;
  assign m1    = miss_valid_if1 && !own_q[0] && line1 == line_q;
  assign m2    = miss_valid_if2 && !own_q[1] && line2 == line_q;
  assign mem_req_addr = line_q;
  assign fill_set     = line_q[OFFSET_BITS +: INDEX_BITS];
  assign fill_tag     = line_q[63 -: TAG_BITS];
  assign fill_way     = way_q;
  assign fill_beat    = beat_q;
  assign fill_data    = state_q == WAIT ? mem_resp_data : '0;
  assign busy         = state_q != IDLE;
  // arbitration, duplicate-miss merging and refill sequencing
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    line_d = line_q;
    own_d = own_q;
    way_d = way_q;
    beat_d = beat_q;
    miss_ready_if1 = 1'b0;
    miss_ready_if2 = 1'b0;
    mem_req_valid = 1'b0;
    fill_we = 1'b0;
    fill_tag_we = 1'b0;
    fill_done_if1 = 1'b0;
    fill_done_if2 = 1'b0;
    case (state_q)
      IDLE: begin
        miss_ready_if1 = g1;
        miss_ready_if2 = g2;
        if (g1 || g2) begin
          line_d = gline;
          own_d = {g2, g1};
          way_d = victim_q[gline[OFFSET_BITS +: INDEX_BITS]];
          rr_d = rr_q ^ (miss_valid_if1 && miss_valid_if2 && !same);
          state_d = REQ;
        end
      end
      REQ, WAIT: begin
        miss_ready_if1 = m1;
        miss_ready_if2 = m2;
        own_d = own_q | {m2, m1};
        if (state_q == REQ) begin
          mem_req_valid = 1'b1;
          beat_d = '0;
          state_d = mem_req_ready ? WAIT : REQ;
        end else if (mem_resp_valid) begin
          fill_we = 1'b1;
          beat_d = beat_q + 1'b1;
          fill_tag_we = beat_q == BEAT_BITS'(BEATS - 1);
          state_d = fill_tag_we ? DONE : WAIT;
        end
      end
      DONE: begin
        fill_done_if1 = own_q[0];
        fill_done_if2 = own_q[1];
        own_d = '0;
        state_d = IDLE;
      end
    endcase
  end
  // controller state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      line_q <= '0;
      own_q <= '0;
      way_q <= '0;
      beat_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      line_q <= line_d;
      own_q <= own_d;
      way_q <= way_d;
      beat_q <= beat_d;
    end
  end
  // per-set round-robin victim pointer, advanced once the line is resident
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) victim_q[i] <= '0;
    end else if (state_q == DONE) begin
      victim_q[fill_set] <= victim_q[fill_set] + 1'b1;
    end
  end
endmodule

// File: tb/tb_l1_icache_refill_ctrl.sv
// tb_l1_icache_refill_ctrl: directed self-checking bench for the I-cache refill controller
module tb_l1_icache_refill_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid_if1, miss_valid_if2;
  logic [63:0] miss_addr_if1, miss_addr_if2;
  logic        miss_ready_if1, miss_ready_if2, fill_done_if1, fill_done_if2;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [63:0] mem_req_addr, mem_resp_data, fill_data;
  logic        fill_we, fill_tag_we, busy;
  logic [6:0]  fill_set;
  logic [2:0]  fill_way, fill_beat;
  logic [50:0] fill_tag;
  int          total = 0;
  int          passed = 0;
  int          reqs = 0;
  int          r0;
  logic [63:0] a;

  l1_icache_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_valid_if1(miss_valid_if1), .miss_addr_if1(miss_addr_if1),
    .miss_ready_if1(miss_ready_if1), .fill_done_if1(fill_done_if1),
    .miss_valid_if2(miss_valid_if2), .miss_addr_if2(miss_addr_if2),
    .miss_ready_if2(miss_ready_if2), .fill_done_if2(fill_done_if2),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .fill_we(fill_we), .fill_set(fill_set), .fill_way(fill_way), .fill_beat(fill_beat),
    .fill_data(fill_data), .fill_tag_we(fill_tag_we), .fill_tag(fill_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && mem_req_valid && mem_req_ready) reqs++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic miss1(input logic [63:0] addr);
    miss_valid_if1 = 1'b1;
    miss_addr_if1 = addr;
    #1;
    chk("grant_if1", miss_ready_if1, 1);
    tick;
    miss_valid_if1 = 1'b0;
  endtask

  // called with the controller in REQ; L2 accepts at once and returns 8 back-to-back beats
  task automatic fill(input logic [63:0] addr, input logic [6:0] set, input logic [2:0] way,
                      input logic [50:0] tag, input logic d1, input logic d2,
                      input int mb, input logic [63:0] maddr);
    mem_req_ready = 1'b1;
    #1;
    chk("req_valid", mem_req_valid, 1);
    chk("req_addr", mem_req_addr, addr);
    tick;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data = 64'hD0D0_0000_0000_0000 | 64'(i);
      if (i == mb) begin
        miss_valid_if2 = 1'b1;
        miss_addr_if2 = maddr;
      end
      #1;
      chk("fill_we", fill_we, 1);
      chk("fill_beat", fill_beat, 64'(i));
      chk("fill_data", fill_data, 64'hD0D0_0000_0000_0000 | 64'(i));
      chk("fill_set", fill_set, 64'(set));
      chk("fill_way", fill_way, 64'(way));
      chk("fill_tag_we", fill_tag_we, 64'(i == 7));
      if (i == 7) chk("fill_tag", fill_tag, 64'(tag));
      if (i == mb) chk("merge_ready_if2", miss_ready_if2, 1);
      tick;
      if (i == mb) miss_valid_if2 = 1'b0;
    end
    mem_resp_valid = 1'b0;
    #1;
    chk("done_if1", fill_done_if1, 64'(d1));
    chk("done_if2", fill_done_if2, 64'(d2));
    chk("busy_done", busy, 1);
    tick;
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    miss_valid_if1 = 0; miss_valid_if2 = 0; miss_addr_if1 = 0; miss_addr_if2 = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_fill_we", fill_we, 0);
    chk("rst_tag_we", fill_tag_we, 0);
    chk("rst_done", {fill_done_if1, fill_done_if2}, 0);
    // single IF1 miss: set 65, tag 0
    miss1(64'h1040);
    fill(64'h1040, 7'd65, 3'd0, 51'd0, 1, 0, -1, 0);
    // both valid, different lines: IF1 first
    miss_valid_if1 = 1; miss_addr_if1 = 64'h2000;
    miss_valid_if2 = 1; miss_addr_if2 = 64'h4000;
    #1;
    chk("arb1_if1", miss_ready_if1, 1);
    chk("arb1_if2", miss_ready_if2, 0);
    tick;
    miss_valid_if1 = 0;
    #1;
    chk("arb1_if2_held", miss_ready_if2, 0);
    fill(64'h2000, 7'd0, 3'd0, 51'd1, 1, 0, -1, 0);
    #1;
    chk("arb1_if2_late", miss_ready_if2, 1);
    tick;
    miss_valid_if2 = 0;
    fill(64'h4000, 7'd0, 3'd1, 51'd2, 0, 1, -1, 0);
    // both valid again: IF2 favoured now
    miss_valid_if1 = 1; miss_valid_if2 = 1;
    #1;
    chk("arb2_if1", miss_ready_if1, 0);
    chk("arb2_if2", miss_ready_if2, 1);
    tick;
    miss_valid_if2 = 0;
    fill(64'h4000, 7'd0, 3'd2, 51'd2, 0, 1, -1, 0);
    #1;
    chk("arb2_if1_late", miss_ready_if1, 1);
    tick;
    miss_valid_if1 = 0;
    fill(64'h2000, 7'd0, 3'd3, 51'd1, 1, 0, -1, 0);
    // merge: IF2 joins on beat 3 with same line
    r0 = reqs;
    miss1(64'h3000);
    fill(64'h3000, 7'd64, 3'd0, 51'd1, 1, 1, 3, 64'h3038);
    chk("merge_one_req", 64'(reqs), 64'(r0 + 1));
    // victim rotation in set 5
    for (int t = 1; t <= 9; t++) begin
      a = (64'(t) << 13) | (64'd5 << 6);
      miss1(a);
      fill(a, 7'd5, 3'((t - 1) % 8), 51'(t), 1, 0, -1, 0);
    end
    a = (64'd1 << 13) | (64'd6 << 6);
    miss1(a);
    fill(a, 7'd6, 3'd0, 51'd1, 1, 0, -1, 0);
    // backpressure and beat gaps
    a = 64'h8000_0000_0000_0040;
    miss1(a);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_req_valid", mem_req_valid, 1);
      chk("bp_req_addr", mem_req_addr, a);
      tick;
    end
    mem_req_ready = 1;
    #1;
    chk("bp_req_addr_acc", mem_req_addr, a);
    tick;
    mem_req_ready = 0;
    for (int i = 0; i < 8; i++) begin
      mem_resp_valid = 1;
      mem_resp_data = 64'h1111 * 64'(i + 1);
      #1;
      chk("gap_we", fill_we, 1);
      chk("gap_beat", fill_beat, 64'(i));
      chk("gap_data", fill_data, 64'h1111 * 64'(i + 1));
      if (i == 7) begin
        chk("gap_tag_we", fill_tag_we, 1);
        chk("gap_tag", fill_tag, 64'h4_0000_0000_0000);
      end
      tick;
      mem_resp_valid = 0;
      if (i < 7) begin
        for (int g = 0; g < 2; g++) begin
          #1;
          chk("gap_idle_we", fill_we, 0);
          tick;
        end
      end
    end
    #1;
    chk("gap_done", fill_done_if1, 1);
    tick;
    mem_resp_valid = 1;
    #1;
    chk("stray_we", fill_we, 0);
    chk("stray_busy", busy, 0);
    tick;
    mem_resp_valid = 0;
    // reset mid-refill after beat 4
    miss1(64'h5000);
    mem_req_ready = 1;
    #1;
    tick;
    mem_req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      mem_resp_valid = 1;
      #1;
      chk("pre_rst_we", fill_we, 1);
      tick;
    end
    mem_resp_valid = 0;
    rst = 1;
    tick;
    rst = 0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_req_valid", mem_req_valid, 0);
    chk("mr_req_addr", mem_req_addr, 0);
    chk("mr_we", fill_we, 0);
    chk("mr_tag_we", fill_tag_we, 0);
    chk("mr_set", fill_set, 0);
    chk("mr_way", fill_way, 0);
    chk("mr_beat", fill_beat, 0);
    chk("mr_tag", fill_tag, 0);
    chk("mr_data", fill_data, 0);
    chk("mr_done", {fill_done_if1, fill_done_if2}, 0);
    for (int i = 5; i < 8; i++) begin
      mem_resp_valid = 1;
      #1;
      chk("post_rst_we", fill_we, 0);
      chk("post_rst_done", fill_done_if1, 0);
      tick;
    end
    mem_resp_valid = 0;
    #1;
    chk("post_rst_nodone", fill_done_if1, 0);
    miss1(64'h5000);
    fill(64'h5000, 7'd64, 3'd0, 51'd2, 1, 0, -1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
